// File: rtl/resource_pkg.sv
// Shared constants and types for the consumable-pool scheduler.
package resource_pkg;

  localparam int unsigned NREQ_DEF     = 3;
  localparam int unsigned ENERGY_W_DEF = 8;
  localparam int unsigned TRACER_W_DEF = 6;
  localparam int unsigned FLUID_W_DEF  = 4;
  // Request amounts are always 8 bits wide regardless of pool widths.
  localparam int unsigned AMT_W        = 8;

  // Pool select encoding carried on req_kind.
  localparam logic [1:0] KIND_ENERGY  = 2'b00;
  localparam logic [1:0] KIND_TRACER  = 2'b01;
  localparam logic [1:0] KIND_FLUID   = 2'b10;
  localparam logic [1:0] KIND_ILLEGAL = 2'b11;

  // Full (refilled) pool values for the default widths.
  localparam logic [ENERGY_W_DEF-1:0] ENERGY_FULL = {ENERGY_W_DEF{1'b1}};
  localparam logic [TRACER_W_DEF-1:0] TRACER_FULL = {TRACER_W_DEF{1'b1}};
  localparam logic [FLUID_W_DEF-1:0]  FLUID_FULL  = {FLUID_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StResp
  } state_e;

endpackage

// File: rtl/resource_scheduler_if.sv
// Requester-side bus of the scheduler: request payloads in, pulses and pool levels out.
interface resource_scheduler_if #(
  parameter int unsigned NREQ     = resource_pkg::NREQ_DEF,
  parameter int unsigned ENERGY_W = resource_pkg::ENERGY_W_DEF,
  parameter int unsigned TRACER_W = resource_pkg::TRACER_W_DEF,
  parameter int unsigned FLUID_W  = resource_pkg::FLUID_W_DEF
);

  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   req_kind;
  logic [8*NREQ-1:0]   req_amt;
  logic                refill;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     deny;
  logic                busy;
  logic [ENERGY_W-1:0] energy;
  logic [TRACER_W-1:0] tracers;
  logic [FLUID_W-1:0]  fluid;
  logic [2:0]          empty;

  // Requesting subsystems.
  modport master (
    output req, req_kind, req_amt, refill,
    input  grant, deny, busy, energy, tracers, fluid, empty
  );

  // The scheduler itself.
  modport slave (
    input  req, req_kind, req_amt, refill,
    output grant, deny, busy, energy, tracers, fluid, empty
  );

endinterface

// File: rtl/resource_sub.sv
// Ripple adder-subtractor: diff = a + (b ^ sub) + sub; carry out doubles as no-borrow.
module resource_sub #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] diff_o,
  output logic         no_borrow_o
);

  logic [W-1:0] b_eff;
  logic         carry;

  assign b_eff = b_i ^ {W{sub_i}};

  // Bit-serial carry chain; carry out is high when a >= b in subtract mode.
  always_comb begin
    carry  = sub_i;
    diff_o = '0;
    for (int i = 0; i < int'(W); i++) begin
      diff_o[i] = a_i[i] ^ b_eff[i] ^ carry;
      carry     = (a_i[i] & b_eff[i]) | (carry & (a_i[i] ^ b_eff[i]));
    end
    no_borrow_o = carry;
  end

endmodule

// File: rtl/resource_scheduler.sv
// Round-robin arbiter owning the energy/tracer/fluid pools; grants and debits or denies.
module resource_scheduler
  import resource_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned ENERGY_W = ENERGY_W_DEF,
  parameter int unsigned TRACER_W = TRACER_W_DEF,
  parameter int unsigned FLUID_W  = FLUID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  resource_scheduler_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NREQ);

  localparam logic [ENERGY_W-1:0] EnergyFull = {ENERGY_W{1'b1}};
  localparam logic [TRACER_W-1:0] TracerFull = {TRACER_W{1'b1}};
  localparam logic [FLUID_W-1:0]  FluidFull  = {FLUID_W{1'b1}};

  state_e              state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     idx_q;
  logic [1:0]          kind_q;
  logic [AMT_W-1:0]    amt_q;
  logic [AMT_W-1:0]    diff_q;
  logic                ok_q;
  logic                refill_pend_q;
  logic [NREQ-1:0]     grant_q;
  logic [NREQ-1:0]     deny_q;
  logic                busy_q;
  logic [ENERGY_W-1:0] energy_q;
  logic [TRACER_W-1:0] tracers_q;
  logic [FLUID_W-1:0]  fluid_q;

  logic                win_valid;
  logic [IdxW-1:0]     win_idx;
  int                  scan;
  logic [AMT_W-1:0]    pool_sel;
  logic [AMT_W-1:0]    diff;
  logic                no_borrow;
  logic                ok_d;

  // Round-robin winner: first asserted req scanning upward from rr_ptr with wrap.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= int'(NREQ)) scan = scan - int'(NREQ);
      if (!win_valid && bus.req[scan]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(scan);
      end
    end
  end

  // Zero-extend the addressed pool so amount bits above its width fail the check.
  always_comb begin
    pool_sel = '0;
    case (kind_q)
      KIND_ENERGY: pool_sel = AMT_W'(energy_q);
      KIND_TRACER: pool_sel = AMT_W'(tracers_q);
      KIND_FLUID:  pool_sel = AMT_W'(fluid_q);
      default:     pool_sel = '0;
    endcase
  end

  // One shared subtractor serves all pools; no_borrow means amt <= pool.
  resource_sub #(
    .W (AMT_W)
  ) u_sub (
    .a_i         (pool_sel),
    .b_i         (amt_q),
    .sub_i       (1'b1),
    .diff_o      (diff),
    .no_borrow_o (no_borrow)
  );

  assign ok_d = (kind_q != KIND_ILLEGAL) && no_borrow;

  // Scheduler FSM: IDLE picks a winner or refills, CHECK decides, RESP pulses and debits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      idx_q         <= '0;
      kind_q        <= KIND_ENERGY;
      amt_q         <= '0;
      diff_q        <= '0;
      ok_q          <= 1'b0;
      refill_pend_q <= 1'b0;
      grant_q       <= '0;
      deny_q        <= '0;
      busy_q        <= 1'b0;
      energy_q      <= EnergyFull;
      tracers_q     <= TracerFull;
      fluid_q       <= FluidFull;
    end else begin
      grant_q <= '0;
      deny_q  <= '0;
      if (bus.refill) refill_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (refill_pend_q) begin
            energy_q      <= EnergyFull;
            tracers_q     <= TracerFull;
            fluid_q       <= FluidFull;
            // A pulse landing on this very edge still leaves one refill pending.
            refill_pend_q <= bus.refill;
          end else if (win_valid) begin
            idx_q   <= win_idx;
            kind_q  <= bus.req_kind[2*win_idx +: 2];
            amt_q   <= bus.req_amt[AMT_W*win_idx +: AMT_W];
            busy_q  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          ok_q           <= ok_d;
          diff_q         <= diff;
          grant_q[idx_q] <= ok_d;
          deny_q[idx_q]  <= !ok_d;
          state_q        <= StResp;
        end
        StResp: begin
          // Pools cannot change between CHECK and here, so the latched diff is current.
          if (ok_q) begin
            case (kind_q)
              KIND_ENERGY: energy_q  <= diff_q[ENERGY_W-1:0];
              KIND_TRACER: tracers_q <= diff_q[TRACER_W-1:0];
              KIND_FLUID:  fluid_q   <= diff_q[FLUID_W-1:0];
              default:     ;
            endcase
          end
          rr_ptr_q <= (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.deny    = deny_q;
  assign bus.busy    = busy_q;
  assign bus.energy  = energy_q;
  assign bus.tracers = tracers_q;
  assign bus.fluid   = fluid_q;
  assign bus.empty   = {fluid_q == '0, tracers_q == '0, energy_q == '0};

endmodule

// File: tb/tb_resource_scheduler.sv
// Directed plus randomized checks of resource_scheduler against a pool/round-robin model.
module tb_resource_scheduler;
  import resource_pkg::*;

  localparam int N = int'(NREQ_DEF);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  resource_scheduler_if bus ();

  resource_scheduler u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests, pool levels and the next round-robin start.
  logic [N-1:0] m_req;
  int           m_kind [N];
  int           m_amt  [N];
  int           pool   [3];
  int           full   [3];
  int           ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req = m_req;
    for (int i = 0; i < N; i++) begin
      bus.req_kind[2*i +: 2] = 2'(m_kind[i]);
      bus.req_amt[8*i +: 8]  = 8'(m_amt[i]);
    end
  endtask

  task automatic check_pools(input string tag);
    check({tag, " energy"},  32'(bus.energy),  32'(pool[0]));
    check({tag, " tracers"}, 32'(bus.tracers), 32'(pool[1]));
    check({tag, " fluid"},   32'(bus.fluid),   32'(pool[2]));
    check({tag, " empty"},   32'(bus.empty),
          {29'd0, pool[2] == 0, pool[1] == 0, pool[0] == 0});
  endtask

  // One full transaction from the current negedge; ends at the negedge after E2.
  task automatic serve(input string tag, input bit drop);
    int           w;
    bit           ok;
    logic [N-1:0] onehot;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && m_req[(ptr + k) % N]) w = (ptr + k) % N;
    check({tag, " has request"}, 32'(m_req != '0), 32'd1);
    if (w < 0) return;
    ok = 1'b0;
    if (m_kind[w] != 3) ok = (m_amt[w] <= pool[m_kind[w]]);
    onehot    = '0;
    onehot[w] = 1'b1;
    drive();
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy@check"},  32'(bus.busy),  32'd1);
    check({tag, " quiet@check"}, 32'(bus.grant | bus.deny), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " grant"}, 32'(bus.grant), ok ? 32'(onehot) : 32'd0);
    check({tag, " deny"},  32'(bus.deny),  ok ? 32'd0 : 32'(onehot));
    if (drop) begin
      m_req[w] = 1'b0;
      drive();
    end
    if (ok) pool[m_kind[w]] -= m_amt[w];
    ptr = (w + 1) % N;
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy@idle"}, 32'(bus.busy), 32'd0);
    check({tag, " pulse gone"}, 32'(bus.grant | bus.deny), 32'd0);
    check_pools(tag);
  endtask

  task automatic do_refill();
    bus.refill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.refill = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pool = full;
    check_pools("refill idle");
  endtask

  task automatic set_req(input int i, input int kind, input int amt);
    m_req[i]  = 1'b1;
    m_kind[i] = kind;
    m_amt[i]  = amt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    full = '{int'(ENERGY_FULL), int'(TRACER_FULL), int'(FLUID_FULL)};
    pool = full;
    ptr  = 0;
    m_req = '0;
    for (int i = 0; i < N; i++) begin
      m_kind[i] = 0;
      m_amt[i]  = 0;
    end
    bus.refill = 1'b0;
    drive();

    #2 rst_n = 1'b0;
    #10;
    check_pools("reset");
    check("reset grant", 32'(bus.grant), 32'd0);
    check("reset deny",  32'(bus.deny),  32'd0);
    check("reset busy",  32'(bus.busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle busy", 32'(bus.busy), 32'd0);
    check_pools("idle");

    set_req(0, 0, 100);  serve("energy 100", 1'b1);
    set_req(1, 1, 64);   serve("tracer 64 deny", 1'b1);
    set_req(1, 1, 63);   serve("tracer 63 drain", 1'b1);
    set_req(0, 2, 16);   serve("fluid 16 deny", 1'b1);
    set_req(2, 3, 0);    serve("illegal deny", 1'b1);

    // Round robin from pointer 0: all held, served 0,1,2,0.
    for (int i = 0; i < N; i++) set_req(i, 2, 1);
    serve("rr a", 1'b0);
    serve("rr b", 1'b0);
    serve("rr c", 1'b0);
    serve("rr d", 1'b0);
    m_req = '0;
    drive();

    set_req(0, 2, 0);    serve("fluid zero", 1'b1);
    set_req(1, 0, 150);  serve("energy to 5", 1'b1);

    // Refill pulsed during CHECK: request completes, pools full at the next IDLE edge.
    set_req(2, 0, 3);
    drive();
    @(posedge clk);
    @(negedge clk);
    bus.refill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.refill = 1'b0;
    check("refill inflight grant", 32'(bus.grant), 32'd4);
    m_req[2] = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    check("refill inflight energy", 32'(bus.energy), 32'd2);
    @(posedge clk);
    @(negedge clk);
    pool = full;
    ptr  = 0;
    check_pools("refill applied");

    // Reset during RESP aborts the pulse and restores full pools.
    set_req(0, 0, 200);  serve("energy 200", 1'b1);
    set_req(1, 2, 2);
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre-reset grant", 32'(bus.grant), 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort grant", 32'(bus.grant), 32'd0);
    check("abort deny",  32'(bus.deny),  32'd0);
    check("abort busy",  32'(bus.busy),  32'd0);
    pool  = full;
    ptr   = 0;
    m_req = '0;
    drive();
    check_pools("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic; pending requests are held until served.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && $urandom_range(0, 1) == 1)
          set_req(i, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 10)));
      end
      if (m_req == '0) set_req(it % N, int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
      serve("random", 1'b1);
      if (it % 20 == 19) begin
        while (m_req != '0) serve("flush", 1'b1);
        do_refill();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/resource_scheduler.md
# resource_scheduler

Arbitrates spend requests from NREQ suit subsystems against the three consumable pools: energy (8-bit), spider tracers (6-bit) and fluid doses (4-bit). It owns the pool counters and checks each request for sufficiency. It then either debits the pool and grants, or leaves the pool unchanged and denies. It sits between the requesting subsystems and the resource storage and replaces direct loads of the pool registers.

## Interface
- NREQ, 3, number of requesters (2..8)
- ENERGY_W, 8, energy pool width; full value 2^ENERGY_W-1
- TRACER_W, 6, tracer pool width; full value 2^TRACER_W-1
- FLUID_W, 4, fluid pool width; full value 2^FLUID_W-1
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state immediately
- req  in  NREQ  per-requester request level; held until grant or deny
- req_kind  in  2*NREQ  per-requester pool select, slice i = [2i+1:2i]; 00 energy, 01 tracer, 10 fluid, 11 illegal
- req_amt  in  8*NREQ  per-requester unsigned amount, slice i = [8i+7:8i]
- refill  in  1  pulse requesting restore of all pools to full
- grant  out  NREQ  one-hot, one-cycle pulse: request served and pool debited
- deny  out  NREQ  one-hot, one-cycle pulse: request rejected and pool unchanged
- busy  out  1  high whenever the FSM is not IDLE
- energy  out  ENERGY_W  current energy count
- tracers  out  TRACER_W  current tracer count
- fluid  out  FLUID_W  current fluid count
- empty  out  3  {fluid==0, tracers==0, energy==0}

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE behaviour:
  - If refill_pend is set, load all pools to full, clear refill_pend, and stay in IDLE. Refill has priority over requests.
  - Otherwise, if any req is high, choose a winner by round-robin starting at rr_ptr. Latch the winner's index, kind and amount, then go to CHECK.
- CHECK: compute ok = (kind != 11) && (amt <= pool). The comparison is made on the zero-extended pool value, so any amount bit above the pool width forces ok=0. Register ok and go to RESP.
- RESP:
  - Pulse grant[idx] if ok, otherwise deny[idx].
  - On leaving RESP: if ok, pool <= pool - amt. Set rr_ptr = (idx+1) mod NREQ. Go to IDLE.
- amt = 0 is granted and leaves the pool unchanged.
- amt equal to the pool is granted and leaves the pool at 0; the matching empty bit goes high.
- Pools never wrap: there is no path that subtracts beyond 0, and refill is the only increment.
- A refill pulse in any state sets refill_pend. It is applied at the next IDLE edge. Multiple pulses before that edge collapse into one refill.
- If a requester drops req while its request is in flight, the transaction still completes and the pulse is still emitted.

## Timing
- Reset values:
  - energy=2^ENERGY_W-1, tracers=2^TRACER_W-1, fluid=2^FLUID_W-1
  - grant=0, deny=0, busy=0, empty=000
  - state=IDLE, rr_ptr=0, refill_pend=0
- Request sampled at edge E0 (IDLE->CHECK); busy is high from E0.
- grant/deny is high for the single cycle between E1 and E2, i.e. while in RESP.
- Pool counters and empty update at E2 (RESP->IDLE); busy is low after E2.
- Requester rule: drop req (or change its payload) at the edge that ends its grant/deny cycle. IDLE samples again only at E3, so no request is served twice.
- Throughput: one request per 3 cycles.
- Refill latency: at most 3 cycles from the pulse to the pools reading full.
- Reset asserted mid-transaction aborts it: no grant/deny pulse, pools go to full.

## Structure
- Package resource_pkg holds:
  - the kind encoding constants (KIND_ENERGY, KIND_TRACER, KIND_FLUID, KIND_ILLEGAL)
  - the state enum
  - the full-value constants derived from the widths
- Sub-module resource_sub: a parameterised-width ripple adder-subtractor producing diff and no_borrow.
  - One instance per pool, or one shared 8-bit instance muxed by kind.
  - ok is derived from no_borrow; diff feeds the debit.

## Test plan
- Reset then idle: energy=255, tracers=63, fluid=15, grant=deny=0, busy=0.
- req[0], kind 00, amt 100 → grant[0] in cycle 2 after sampling; energy=155 after E2.
- tracers at 63; req[1], kind 01, amt 64 → deny[1], tracers stays 63. Then amt 63 → grant[1], tracers=0, empty[1]=1.
- All three req high with fluid requests of amt 1 → grants in order 0,1,2,0 (round-robin), one grant every 3 cycles, fluid decrements by 1 each.
- Illegal and zero amounts:
  - kind 11, amt 0 → deny.
  - kind 10, amt 0 → grant, fluid unchanged.
- Refill pulse during CHECK after draining energy to 5 → in-flight request completes; next IDLE edge sets energy=255. Reset pulled low during RESP → no pulse, all pools full.
